// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with branch redirect, stall-pending redirect,
// halt handling, sticky misaligned-target flag and a saturating redirect counter.
module fetch_pc_unit #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
    parameter int unsigned             PC_STEP    = 4,
    parameter int unsigned             CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  takeBranchE,
    input  logic [ADDR_WIDTH-1:0] branchTargetE,
    input  logic                  stallF,
    input  logic                  haltE,
    output logic [ADDR_WIDTH-1:0] pcF,
    output logic                  validF,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  halted,
    output logic                  misalignF,
    output logic [CNT_WIDTH-1:0]  branchCount
);

    localparam int unsigned ALIGN_BITS = $clog2(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_q, pend_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic                  misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] target;
    logic                  target_misaligned;
    logic                  redirect_accept;

    assign target            = branchTargetE & ALIGN_MASK;
    assign target_misaligned = |(branchTargetE & ~ALIGN_MASK);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_d          = pend_q;
        valid_d         = 1'b1;
        halted_d        = 1'b0;
        misalign_d      = misalign_q;
        cnt_d           = cnt_q;
        redirect_accept = 1'b0;

        unique case (state_q)
            S_RUN, S_HOLD: begin
                if (takeBranchE) begin
                    // A redirect during HOLD replaces the pending target; if the
                    // stall has lifted it is taken directly without stepping.
                    redirect_accept = 1'b1;
                    if (stallF) begin
                        pend_d  = target;
                        state_d = S_HOLD;
                    end else begin
                        pc_d    = target;
                        state_d = S_RUN;
                    end
                end else if (haltE) begin
                    pend_d   = '0;
                    state_d  = S_HALTED;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (!stallF) begin
                    if (state_q == S_HOLD) begin
                        pc_d    = pend_q;
                        state_d = S_RUN;
                    end else begin
                        pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
                    end
                end
            end
            S_HALTED: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (redirect_accept) begin
            misalign_d = misalign_q | target_misaligned;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        pcF         = pc_q;
        validF      = valid_q;
        halted      = halted_q;
        misalignF   = misalign_q;
        branchCount = cnt_q;
        flushD      = rst & takeBranchE & (state_q != S_HALTED);
        flushE      = rst & takeBranchE & (state_q != S_HALTED);
    end

endmodule
